// File: rtl/cache_port_arbiter.sv
// Two-requester port controller for the 1024x16 data cache.
// Zero-fills the cache after reset, then grants one access per cycle.
module cache_port_arbiter #(
   parameter int unsigned AW             = 10,
   parameter int unsigned DW             = 16,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter bit          FIXED_PRIO     = 1'b0
) (
   input  logic          clk,
   input  logic          Reset,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   output logic          mem_write,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          init_busy
);

   typedef enum logic {INIT, RUN} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_q, clr_d;
   logic          last_q, last_d;
   logic          r0_rvalid_q, r1_rvalid_q;
   logic [DW-1:0] r0_rdata_q, r1_rdata_q;
   logic          win0, win1;

   // last_q = 1 means r1 held the previous grant, so r0 wins the next tie
   assign win0 = r0_req & (~r1_req | FIXED_PRIO | last_q);
   assign win1 = r1_req & ~win0;

   always_comb begin
      state_d   = state_q;
      clr_d     = clr_q;
      last_d    = last_q;
      r0_gnt    = 1'b0;
      r1_gnt    = 1'b0;
      mem_write = 1'b0;
      mem_waddr = r0_addr;
      mem_raddr = r0_addr;
      mem_wdata = r0_wdata;
      if (!Reset) begin
         unique case (state_q)
            INIT: begin
               mem_write = 1'b1;
               mem_waddr = clr_q;
               mem_wdata = '0;
               clr_d     = clr_q + AW'(1);
               if (&clr_q) state_d = RUN;
            end
            RUN: begin
               r0_gnt = win0;
               r1_gnt = win1;
               if (win0 | win1) begin
                  last_d    = win1;
                  mem_write = win1 ? r1_we    : r0_we;
                  mem_waddr = win1 ? r1_addr  : r0_addr;
                  mem_raddr = win1 ? r1_addr  : r0_addr;
                  mem_wdata = win1 ? r1_wdata : r0_wdata;
               end
            end
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= CLEAR_ON_RESET ? INIT : RUN;
         clr_q       <= '0;
         last_q      <= 1'b1;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         last_q      <= last_d;
         r0_rvalid_q <= r0_gnt & ~r0_we;
         r1_rvalid_q <= r1_gnt & ~r1_we;
         if (r0_gnt & ~r0_we) r0_rdata_q <= mem_rdata;
         if (r1_gnt & ~r1_we) r1_rdata_q <= mem_rdata;
      end
   end

   assign r0_rvalid = r0_rvalid_q;
   assign r1_rvalid = r1_rvalid_q;
   assign r0_rdata  = r0_rdata_q;
   assign r1_rdata  = r1_rdata_q;
   assign init_busy = (state_q == INIT);

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter with a behavioural cache model.
// A second instance covers fixed priority with no clear-on-reset.
module tb_cache_port_arbiter;

   logic        clk = 1'b0;
   logic        Reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [9:0]  r0_addr, r1_addr;
   logic [15:0] r0_wdata, r1_wdata;
   logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
   logic [15:0] r0_rdata, r1_rdata;
   logic        mem_write, init_busy;
   logic [9:0]  mem_waddr, mem_raddr;
   logic [15:0] mem_wdata, mem_rdata;

   logic        p_r0_req, p_r1_req;
   logic        p_r0_gnt, p_r0_rvalid, p_r1_gnt, p_r1_rvalid;
   logic [15:0] p_r0_rdata, p_r1_rdata;
   logic        p_mem_write, p_init_busy;
   logic [9:0]  p_mem_waddr, p_mem_raddr;
   logic [15:0] p_mem_wdata;

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   logic [15:0] mem [1024];
   bit          filled;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // cache model: async read, write on clock; starts non-zero
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'hDEAD;
         filled <= 1'b1;
      end else if (mem_write) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_raddr];

   cache_port_arbiter #(
      .AW(10), .DW(16), .CLEAR_ON_RESET(1'b1), .FIXED_PRIO(1'b0)
   ) dut (
      .clk(clk), .Reset(Reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
      .r0_rdata(r0_rdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
      .r1_rdata(r1_rdata),
      .mem_write(mem_write), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
      .mem_rdata(mem_rdata), .init_busy(init_busy)
   );

   cache_port_arbiter #(
      .AW(10), .DW(16), .CLEAR_ON_RESET(1'b0), .FIXED_PRIO(1'b1)
   ) dut_p (
      .clk(clk), .Reset(Reset),
      .r0_req(p_r0_req), .r0_we(1'b0), .r0_addr(10'h001),
      .r0_wdata(16'h0000), .r0_gnt(p_r0_gnt), .r0_rvalid(p_r0_rvalid),
      .r0_rdata(p_r0_rdata),
      .r1_req(p_r1_req), .r1_we(1'b0), .r1_addr(10'h002),
      .r1_wdata(16'h0000), .r1_gnt(p_r1_gnt), .r1_rvalid(p_r1_rvalid),
      .r1_rdata(p_r1_rdata),
      .mem_write(p_mem_write), .mem_waddr(p_mem_waddr),
      .mem_wdata(p_mem_wdata), .mem_raddr(p_mem_raddr),
      .mem_rdata(16'h5A5A), .init_busy(p_init_busy)
   );

   task automatic chk(input string name, input longint act,
                      input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops expected read data whenever a requester shows rvalid
   always @(negedge clk) begin
      exp_t e;
      n_cmp++;
      if (r0_gnt && r1_gnt) begin
         n_err++;
         $display("FAIL two_gnt: got both grants expected one");
      end
      if (r0_rvalid) begin
         if (q0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL r0_spurious_rvalid: got 1 expected 0");
         end else begin
            e = q0.pop_front();
            chk("r0_rdata", r0_rdata, e.d);
            chk("r0_rvalid_cycle", cyc, e.c + 1);
         end
      end
      if (r1_rvalid) begin
         if (q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL r1_spurious_rvalid: got 1 expected 0");
         end else begin
            e = q1.pop_front();
            chk("r1_rdata", r1_rdata, e.d);
            chk("r1_rvalid_cycle", cyc, e.c + 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic acc(input bit who, input bit we, input logic [9:0] a,
                      input logic [15:0] d, input logic [15:0] exp,
                      output int waits);
      exp_t e;
      if (!who) begin
         r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
      end else begin
         r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
      end
      waits = 0;
      @(negedge clk);
      while (!(who ? r1_gnt : r0_gnt) && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 50) begin
         n_cmp++; n_err++;
         $display("FAIL gnt_timeout: got no grant expected grant");
      end else if (!we) begin
         e.d = exp;
         e.c = cyc;
         if (!who) q0.push_back(e);
         else      q1.push_back(e);
      end
      tick();
   endtask

   task automatic init_sweep(input bit chk_r1);
      int n = 0;
      while (n < 2000) begin
         @(negedge clk);
         if (!init_busy) break;
         chk("init_waddr", mem_waddr, n % 1024);
         chk("init_write", mem_write, 1);
         chk("init_wdata", mem_wdata, 0);
         if (chk_r1) chk("init_r1_gnt", r1_gnt, 0);
         n++;
      end
      chk("init_len", n, 1024);
   endtask

   initial begin
      exp_t e;
      int   w;
      Reset = 1'b1;
      r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h3; r0_wdata = 16'h1111;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h5; r1_wdata = 16'h0;
      p_r0_req = 1'b0; p_r1_req = 1'b0;

      @(negedge clk);
      chk("rst_r0_gnt", r0_gnt, 0);
      chk("rst_r1_gnt", r1_gnt, 0);
      chk("rst_mem_write", mem_write, 0);
      tick();
      chk("rst_r0_rvalid", r0_rvalid, 0);
      chk("rst_r0_rdata", r0_rdata, 0);
      chk("rst_r1_rdata", r1_rdata, 0);
      chk("rst_init_busy", init_busy, 1);
      chk("rst_p_init_busy", p_init_busy, 0);
      r0_req = 1'b0;
      Reset = 1'b0;

      // zero-fill with r1 read pending throughout
      init_sweep(1'b1);
      chk("t6_first_run_r1_gnt", r1_gnt, 1);
      e.d = 16'h0; e.c = cyc; q1.push_back(e);
      tick();
      r1_req = 1'b0;

      for (int a = 0; a < 1024; a++) acc(1'b0, 1'b0, 10'(a), 16'h0, 16'h0, w);
      r0_req = 1'b0;

      acc(1'b0, 1'b1, 10'h3A5, 16'hBEEF, 16'h0, w);
      chk("t2_wr_wait", w, 0);
      acc(1'b0, 1'b0, 10'h3A5, 16'h0, 16'hBEEF, w);
      chk("t2_rd_wait", w, 0);
      r0_req = 1'b0;
      acc(1'b1, 1'b1, 10'h010, 16'h1234, 16'h0, w);
      r1_req = 1'b0;

      // both read continuously: r0 first since r1 went last
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h3A5;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 10'h010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_r0_gnt", r0_gnt, (i % 2 == 0));
         chk("t3_r1_gnt", r1_gnt, (i % 2 == 1));
         e.c = cyc;
         if (r0_gnt) begin e.d = 16'hBEEF; q0.push_back(e); end
         if (r1_gnt) begin e.d = 16'h1234; q1.push_back(e); end
         tick();
      end
      r0_req = 1'b0; r1_req = 1'b0;
      repeat (3) tick();
      r0_req = 1'b1; r1_req = 1'b1;
      @(negedge clk);
      chk("idle_keep_r1_gnt", r1_gnt, 1);
      chk("idle_keep_r0_gnt", r0_gnt, 0);
      e.c = cyc;
      if (r1_gnt) begin e.d = 16'h1234; q1.push_back(e); end
      if (r0_gnt) begin e.d = 16'hBEEF; q0.push_back(e); end
      tick();
      r0_req = 1'b0; r1_req = 1'b0;
      tick();

      // fixed priority instance
      p_r0_req = 1'b1; p_r1_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_p_r0_gnt", p_r0_gnt, 1);
         chk("t4_p_r1_gnt", p_r1_gnt, 0);
         tick();
      end
      p_r0_req = 1'b0;
      @(negedge clk);
      chk("t4_p_r1_gnt6", p_r1_gnt, 1);
      chk("t4_p_r0_gnt6", p_r0_gnt, 0);
      chk("t4_p_r0_rdata", p_r0_rdata, 16'h5A5A);
      tick();
      p_r1_req = 1'b0;
      @(negedge clk);
      chk("t4_p_r1_rvalid", p_r1_rvalid, 1);
      chk("t4_p_r1_rdata", p_r1_rdata, 16'h5A5A);
      tick();

      // reset mid-INIT with a read request racing the reset
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      w = 0;
      @(negedge clk);
      while (mem_waddr != 10'd500 && w < 2000) begin
         w++;
         @(negedge clk);
      end
      chk("t5_reach_500", mem_waddr, 500);
      tick();
      Reset = 1'b1;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h3A5;
      @(negedge clk);
      chk("t5_rst_r0_gnt", r0_gnt, 0);
      chk("t5_rst_mem_write", mem_write, 0);
      tick();
      Reset = 1'b0;
      r0_req = 1'b0;
      init_sweep(1'b0);
      tick();
      tick();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
